// File: rtl/nios_gpu_run_ctrl_pkg.sv
// Shared types and constants for the GPU run controller: FSM states,
// Avalon register addresses and register bit positions.
package nios_gpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic [1:0] ADDR_STATUS = 2'd0;
   localparam logic [1:0] ADDR_FRAME  = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_LAST   = 2'd3;

   localparam int STAT_BUSY     = 0;
   localparam int STAT_DONE     = 1;
   localparam int STAT_TIMEOUT  = 2;
   localparam int STAT_OVERRUN  = 3;

   localparam int CTRL_IRQ_EN   = 0;
   localparam int CTRL_ABORT    = 1;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/nios_gpu_run_ctrl_if.sv
// Avalon-MM register port of the GPU run controller (zero wait states).
interface nios_gpu_run_ctrl_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_gpu_run_ctrl_regs.sv
// Register file of the GPU run controller: Avalon decode, sticky status flags,
// frame counter, last job duration, irq enable and registered interrupt.
module nios_gpu_run_regs
   import nios_gpu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   nios_gpu_run_ctrl_if.slave avs,
   input  logic              busy,
   input  logic              done_set,
   input  logic              timeout_set,
   input  logic              overrun_set,
   input  logic [31:0]       cyc_cnt,
   output logic              abort,
   output logic              irq
);
   logic             wr_s, wr_status_s, wr_frame_s, wr_ctrl_s, unused_wd_s;
   logic             done_flag_q, done_flag_d;
   logic             timeout_flag_q, timeout_flag_d;
   logic             overrun_flag_q, overrun_flag_d;
   logic             irq_en_q, irq_en_d;
   logic             irq_q, irq_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [31:0]      last_cycles_q, last_cycles_d;

   // Sets always beat same-cycle software clears.
   always_comb begin
      wr_s        = avs.chipselect & ~avs.write_n;
      wr_status_s = wr_s && (avs.address == ADDR_STATUS);
      wr_frame_s  = wr_s && (avs.address == ADDR_FRAME);
      wr_ctrl_s   = wr_s && (avs.address == ADDR_CTRL);
      abort       = wr_ctrl_s && avs.writedata[CTRL_ABORT];
      unused_wd_s = ^avs.writedata[31:4];

      done_flag_d    = done_set    | (done_flag_q    & ~(wr_status_s & avs.writedata[STAT_DONE]));
      timeout_flag_d = timeout_set | (timeout_flag_q & ~(wr_status_s & avs.writedata[STAT_TIMEOUT]));
      overrun_flag_d = overrun_set | (overrun_flag_q & ~(wr_status_s & avs.writedata[STAT_OVERRUN]));

      if (done_set) begin
         frame_cnt_d = wr_frame_s ? CNT_W'(1) : frame_cnt_q + CNT_W'(1);
      end else begin
         frame_cnt_d = wr_frame_s ? {CNT_W{1'b0}} : frame_cnt_q;
      end

      last_cycles_d = done_set  ? cyc_cnt : last_cycles_q;
      irq_en_d      = wr_ctrl_s ? avs.writedata[CTRL_IRQ_EN] : irq_en_q;
      irq_d         = irq_en_q & (done_flag_q | timeout_flag_q);

      case (avs.address)
         ADDR_STATUS: avs.readdata = {28'd0, overrun_flag_q, timeout_flag_q, done_flag_q, busy};
         ADDR_FRAME:  avs.readdata = 32'(frame_cnt_q);
         ADDR_CTRL:   avs.readdata = {31'd0, irq_en_q};
         ADDR_LAST:   avs.readdata = last_cycles_q;
         default:     avs.readdata = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         done_flag_q    <= 1'b0;
         timeout_flag_q <= 1'b0;
         overrun_flag_q <= 1'b0;
         irq_en_q       <= 1'b0;
         irq_q          <= 1'b0;
         frame_cnt_q    <= {CNT_W{1'b0}};
         last_cycles_q  <= 32'd0;
      end else begin
         done_flag_q    <= done_flag_d;
         timeout_flag_q <= timeout_flag_d;
         overrun_flag_q <= overrun_flag_d;
         irq_en_q       <= irq_en_d;
         irq_q          <= irq_d;
         frame_cnt_q    <= frame_cnt_d;
         last_cycles_q  <= last_cycles_d;
      end
   end

   assign irq = irq_q;

endmodule

// File: rtl/nios_gpu_run_ctrl.sv
// Turns the Nios PIO run level into a one-shot GPU start handshake, times the
// job and reports completion, timeout and overrun through nios_gpu_run_regs.
module nios_gpu_run_ctrl
   import nios_gpu_pkg::*;
#(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
   parameter int          CNT_W          = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              run_in,
   output logic              gpu_start,
   input  logic              gpu_ack,
   input  logic              gpu_done,
   output logic              busy,
   output logic              irq,
   nios_gpu_run_ctrl_if.slave avs
);
   state_e      state_q, state_d, fsm_nxt_s;
   logic [31:0] cyc_cnt_q, cyc_cnt_d;
   logic        run_in_d_q, armed_q, armed_d;
   logic        gpu_start_q, gpu_start_d, busy_q, busy_d;
   logic        rise_s, active_s, timeout_hit_s, abort_s;
   logic        timeout_evt_s, done_set_s, timeout_set_s, overrun_set_s;

   always_comb begin
      rise_s        = run_in & ~run_in_d_q & armed_q;
      active_s      = (state_q == ST_REQ) || (state_q == ST_RUN);
      timeout_hit_s = active_s && (cyc_cnt_q == TIMEOUT_CYCLES - 32'd1) && !gpu_done;
      cyc_cnt_d     = active_s ? sat_inc32(cyc_cnt_q) : cyc_cnt_q;
      fsm_nxt_s     = state_q;
      timeout_evt_s = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rise_s) begin
               fsm_nxt_s = ST_REQ;
               cyc_cnt_d = 32'd0;
            end else begin
               fsm_nxt_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (gpu_ack && gpu_done) begin
               fsm_nxt_s = ST_DONE;
            end else if (gpu_ack) begin
               fsm_nxt_s = ST_RUN;
            end else if (timeout_hit_s) begin
               fsm_nxt_s     = ST_IDLE;
               timeout_evt_s = 1'b1;
            end else begin
               fsm_nxt_s = ST_REQ;
            end
         end
         ST_RUN: begin
            if (gpu_done) begin
               fsm_nxt_s = ST_DONE;
            end else if (timeout_hit_s) begin
               fsm_nxt_s     = ST_IDLE;
               timeout_evt_s = 1'b1;
            end else begin
               fsm_nxt_s = ST_RUN;
            end
         end
         ST_DONE: fsm_nxt_s = ST_IDLE;
         default: fsm_nxt_s = ST_IDLE;
      endcase

      // Abort outranks every FSM outcome, including a completion in DONE.
      state_d       = abort_s ? ST_IDLE : fsm_nxt_s;
      done_set_s    = (state_q == ST_DONE) && !abort_s;
      timeout_set_s = timeout_evt_s && !abort_s;
      overrun_set_s = rise_s && (state_q != ST_IDLE);
      gpu_start_d   = (state_d == ST_REQ);
      busy_d        = (state_d == ST_REQ) || (state_d == ST_RUN);
      armed_d       = armed_q | ~run_in;
   end

   // armed_q keeps a run level held across reset from starting a job until it drops.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cyc_cnt_q   <= 32'd0;
         run_in_d_q  <= 1'b0;
         armed_q     <= ~run_in;
         gpu_start_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_cnt_q   <= cyc_cnt_d;
         run_in_d_q  <= run_in;
         armed_q     <= armed_d;
         gpu_start_q <= gpu_start_d;
         busy_q      <= busy_d;
      end
   end

   assign gpu_start = gpu_start_q;
   assign busy      = busy_q;

   nios_gpu_run_regs #(.CNT_W(CNT_W)) u_regs (
      .clk         (clk),
      .reset_n     (reset_n),
      .avs         (avs),
      .busy        (busy_q),
      .done_set    (done_set_s),
      .timeout_set (timeout_set_s),
      .overrun_set (overrun_set_s),
      .cyc_cnt     (cyc_cnt_q),
      .abort       (abort_s),
      .irq         (irq)
   );

endmodule

// File: tb/tb_nios_gpu_run_ctrl.sv
// Directed plus randomized bench for nios_gpu_run_ctrl, checked against a
// job-level reference model of flags, frame count, last duration and irq.
module tb_nios_gpu_run_ctrl;
   import nios_gpu_pkg::*;

   localparam int T  = 16;
   localparam int CW = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic run_in = 1'b0;
   logic gpu_ack = 1'b0;
   logic gpu_done = 1'b0;
   logic gpu_start, busy, irq;

   nios_gpu_run_ctrl_if avs();

   nios_gpu_run_ctrl #(.TIMEOUT_CYCLES(32'(T)), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .run_in    (run_in),
      .gpu_start (gpu_start),
      .gpu_ack   (gpu_ack),
      .gpu_done  (gpu_done),
      .busy      (busy),
      .irq       (irq),
      .avs       (avs)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   bit m_done, m_to, m_ovr, m_irq_en;
   int m_frame, m_last;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_wr(input logic [1:0] a, input logic [31:0] d);
      avs.address    = a;
      avs.chipselect = 1'b1;
      avs.write_n    = 1'b0;
      avs.writedata  = d;
   endtask

   task automatic end_wr();
      avs.chipselect = 1'b0;
      avs.write_n    = 1'b1;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      start_wr(a, d);
      step();
      end_wr();
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      avs.address = a;
      #1;
      d = avs.readdata;
   endtask

   task automatic model_reset();
      m_done = 1'b0; m_to = 1'b0; m_ovr = 1'b0; m_irq_en = 1'b0;
      m_frame = 0; m_last = 0;
   endtask

   task automatic model_status_clear(input logic [31:0] d);
      if (d[1]) m_done = 1'b0;
      if (d[2]) m_to   = 1'b0;
      if (d[3]) m_ovr  = 1'b0;
   endtask

   // Full register/irq comparison; only valid while idle and settled.
   task automatic check_all(input string ctx);
      logic [31:0] d;
      rd(ADDR_STATUS, d); chk({ctx, ".status"}, d, {28'd0, m_ovr, m_to, m_done, 1'b0});
      rd(ADDR_FRAME, d);  chk({ctx, ".frame"},  d, 32'(m_frame));
      rd(ADDR_CTRL, d);   chk({ctx, ".ctrl"},   d, {31'd0, m_irq_en});
      rd(ADDR_LAST, d);   chk({ctx, ".last"},   d, 32'(m_last));
      chk({ctx, ".irq"},  {31'd0, irq},  {31'd0, m_irq_en & (m_done | m_to)});
      chk({ctx, ".busy"}, {31'd0, busy}, 32'd0);
      chk({ctx, ".start"},{31'd0, gpu_start}, 32'd0);
   endtask

   // One job: ack in REQ-cycle ia, done in cycle kd (kd >= ia), optional abort
   // write in cycle abort_at, optional run_in re-pulse, optional frame clear in DONE.
   task automatic run_job(input string ctx, input int ia, input int kd, input int abort_at,
                          input bit ovr, input bit clr_in_done, output int start_cycles);
      int k;
      bit fin;
      int outcome;
      start_cycles = 0; k = 0; fin = 1'b0; outcome = 0;
      run_in = 1'b1;
      step();
      while (!fin) begin
         gpu_ack  = (k == ia);
         gpu_done = (k == kd);
         if (ovr && k == ia + 1) run_in = 1'b0;
         if (ovr && k == ia + 2) run_in = 1'b1;
         if (k == abort_at) start_wr(ADDR_CTRL, {30'd0, 1'b1, m_irq_en});
         chk({ctx, ".job_busy"},  {31'd0, busy}, 32'd1);
         chk({ctx, ".job_start"}, {31'd0, gpu_start}, {31'd0, k <= ia});
         if (gpu_start) start_cycles++;
         if (k == abort_at) begin
            outcome = 2; fin = 1'b1;
         end else if (k == kd) begin
            outcome = 0; fin = 1'b1;
         end else if (k == T - 1) begin
            outcome = 1; fin = 1'b1;
         end
         step();
         if (!fin) k++;
      end
      gpu_ack = 1'b0; gpu_done = 1'b0;
      end_wr();
      chk({ctx, ".post_busy"},  {31'd0, busy}, 32'd0);
      chk({ctx, ".post_start"}, {31'd0, gpu_start}, 32'd0);
      if (outcome == 0 && clr_in_done) start_wr(ADDR_FRAME, 32'd0);
      step();
      end_wr();
      if (ovr && k >= ia + 2) m_ovr = 1'b1;
      case (outcome)
         0: begin
            m_done  = 1'b1;
            m_last  = k + 1;
            m_frame = clr_in_done ? 1 : (m_frame + 1) % (1 << CW);
         end
         1: m_to = 1'b1;
         default: ;
      endcase
      run_in = 1'b0;
      step();
      check_all(ctx);
   endtask

   initial begin
      int sc;
      avs.address = 2'd0; avs.chipselect = 1'b0; avs.write_n = 1'b1; avs.writedata = 32'd0;
      model_reset();
      step(); step();
      reset_n = 1'b1;
      step();
      check_all("reset");

      bus_wr(ADDR_CTRL, 32'd1); m_irq_en = 1'b1;
      run_job("basic", 1, 11, -1, 1'b0, 1'b0, sc);
      bus_wr(ADDR_STATUS, 32'h2); m_done = 1'b0;
      chk("irq_clear_lag", {31'd0, irq}, 32'd1);
      step();
      chk("irq_cleared", {31'd0, irq}, 32'd0);

      run_job("timeout", 99, 99, -1, 1'b0, 1'b0, sc);
      chk("timeout.start_cycles", 32'(sc), 32'(T));
      bus_wr(ADDR_STATUS, 32'hE); model_status_clear(32'hE);

      run_job("overrun", 1, 8, -1, 1'b1, 1'b0, sc);
      bus_wr(ADDR_STATUS, 32'hE); model_status_clear(32'hE);
      run_job("tie", 2, T - 1, -1, 1'b0, 1'b0, sc);

      bus_wr(ADDR_STATUS, 32'hE); model_status_clear(32'hE);
      bus_wr(ADDR_CTRL, 32'd0); m_irq_en = 1'b0;
      run_job("abort", 1, 6, 6, 1'b0, 1'b0, sc);

      bus_wr(ADDR_FRAME, 32'd0); m_frame = 0;
      for (int j = 0; j < 4; j++) run_job("wrap", 0, 3, -1, 1'b0, 1'b0, sc);
      run_job("pre_race", 1, 2, -1, 1'b0, 1'b0, sc);
      run_job("race", 1, 4, -1, 1'b0, 1'b1, sc);

      run_in = 1'b1;
      step(); step();
      chk("midreset.busy_before", {31'd0, busy}, 32'd1);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      model_reset();
      check_all("midreset");
      for (int j = 0; j < 4; j++) begin
         step();
         chk("midreset.held_high", {31'd0, busy}, 32'd0);
      end
      run_in = 1'b0;
      step();
      run_job("after_reset", 0, 5, -1, 1'b0, 1'b0, sc);

      for (int i = 0; i < 24; i++) begin
         int ia, kd, ab;
         bit ov, cl, en;
         logic [31:0] wd;
         if ($urandom_range(0, 3) == 0) begin
            wd = $urandom;
            bus_wr(ADDR_STATUS, wd);
            model_status_clear(wd);
         end
         if ($urandom_range(0, 3) == 0) begin
            en = 1'($urandom_range(0, 1));
            bus_wr(ADDR_CTRL, {31'd0, en});
            m_irq_en = en;
         end
         ia = int'($urandom_range(0, 4));
         kd = ia + int'($urandom_range(0, T));
         ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, (kd < T - 1) ? kd : T - 1)) : -1;
         ov = ($urandom_range(0, 3) == 0);
         cl = ($urandom_range(0, 4) == 0);
         run_job("rand", ia, kd, ab, ov, cl, sc);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/nios_gpu_run_ctrl.md
Name: nios_gpu_run_ctrl

Overview:
Downstream consumer of the single-bit GPU "run" PIO output driven by the Nios.
- Converts the software-held run level into a one-shot start handshake to the GPU core and tracks the job to completion.
- Exposes status, frame count, control and job-duration registers on a small Avalon-MM slave, plus an interrupt.
- Sits between the PIO run bit and the GPU core start/ack/done interface.

Parameters:
TIMEOUT_CYCLES, 32'd1000000, cycles allowed from entry into REQ until gpu_done before the job is flagged as timed out (minimum 2).
CNT_W, 16, width of the frame counter (1..32).

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset_n  input  1  synchronous active-low reset.
run_in  input  1  run level from the PIO out_port (already synchronous to clk).
gpu_start  output  1  start request to the GPU; held high until gpu_ack.
gpu_ack  input  1  GPU accepts the start (single-cycle pulse or level).
gpu_done  input  1  GPU job-complete pulse.
busy  output  1  high while in REQ or RUN.
irq  output  1  interrupt to the Nios.
address  input  2  Avalon register select.
chipselect  input  1  Avalon select.
write_n  input  1  Avalon write strobe, active-low.
writedata  input  32  Avalon write data.
readdata  output  32  Avalon read data; combinational from address, zero wait states.

Behaviour:
Reset: one clock and one synchronous active-low reset, named clk and reset_n. While reset_n=0 at a clk edge, all state clears:
- FSM to IDLE; gpu_start, busy and irq = 0.
- All sticky flags, frame count, irq_en, last_cycles and run_in_d = 0.
- Reset mid-job drops gpu_start on the next edge with no done or timeout recorded.

Edge detection: run_in_d registers run_in; rise = run_in & ~run_in_d.

FSM (states IDLE, REQ, RUN, DONE):
- IDLE: on rise, go to REQ and clear cyc_cnt to 0.
- REQ: gpu_start=1.
  - gpu_ack & gpu_done in the same cycle -> DONE.
  - gpu_ack alone -> RUN.
- RUN: gpu_done -> DONE.
- DONE (exactly one cycle):
  - set done_flag.
  - frame_cnt += 1, wrapping at 2^CNT_W.
  - last_cycles <= cyc_cnt.
  - next state IDLE.
- cyc_cnt: increments every cycle in REQ/RUN and saturates at 32'hFFFFFFFF.
- Timeout: in REQ/RUN, when cyc_cnt == TIMEOUT_CYCLES-1 and gpu_done is not asserted -> set timeout_flag, go to IDLE, gpu_start drops next cycle. If gpu_done and the timeout coincide, done wins.
- Abort: a write with CONTROL bit1=1 forces IDLE from any state. No done, no count increment. Abort beats gpu_done in the same cycle.
- rise in REQ/RUN/DONE: ignored (no queueing) and sets overrun_flag.
- gpu_done or gpu_ack in IDLE: ignored.

Register map (write = chipselect & ~write_n):
- 0 STATUS
  - read: {28'b0, overrun, timeout, done, busy}.
  - write: 1s in bits[3:1] clear those flags. If a set and a clear hit the same cycle, set wins.
- 1 FRAME_COUNT
  - read: zero-extended frame_cnt.
  - write: any write clears it. An increment in the same cycle wins and the result is 1.
- 2 CONTROL
  - read: {31'b0, irq_en}.
  - write: bit0 -> irq_en; bit1 = abort, self-clearing and reads 0.
- 3 LAST_CYCLES
  - read: last_cycles.
  - write: ignored.

irq is registered: irq <= irq_en & (done_flag | timeout_flag). It updates one cycle after the flag or irq_en changes.

Latency: rise seen at edge N -> gpu_start=1 and busy=1 after edge N+1. gpu_done sampled at edge M in RUN -> STATUS.done visible after edge M+2 (through DONE), irq after edge M+3.

Decomposition:
- Package nios_gpu_pkg:
  - FSM state enum (IDLE, REQ, RUN, DONE).
  - Register address constants (ADDR_STATUS=0, ADDR_FRAME=1, ADDR_CTRL=2, ADDR_LAST=3).
  - STATUS bit-index constants.
- One sub-module is natural: nios_gpu_run_regs, the Avalon decode plus sticky flags, counters and readdata mux. The FSM stays in the top level.

Test Plan:
- Basic job: reset, write CONTROL=1, run_in 0->1, gpu_ack 2 cycles after gpu_start, gpu_done 10 cycles later -> STATUS=0x2, FRAME_COUNT=1, LAST_CYCLES=12, irq=1; write STATUS=0x2 -> irq=0 one cycle later.
- Timeout: TIMEOUT_CYCLES=8, never assert gpu_ack -> gpu_start high exactly 8 cycles, STATUS=0x4, FRAME_COUNT=0, busy=0.
- Overrun and tie-break: run_in toggles 0->1->0->1 during RUN -> STATUS bit3=1 and only one job runs. gpu_done on the timeout cycle -> done=1, timeout=0.
- Abort: write CONTROL=0x2 in RUN in the same cycle as gpu_done -> IDLE, STATUS=0x0, FRAME_COUNT unchanged, CONTROL reads 0x0.
- Counter wrap and clear race: CNT_W=2, run 4 jobs -> FRAME_COUNT=0. Write FRAME_COUNT in a DONE cycle -> reads 1.
- Reset mid-operation: reset_n=0 for 1 cycle during REQ -> gpu_start=0 and all registers 0. run_in held high afterwards starts no job until it falls and rises again.
